// File: rtl/bp_be_mmu_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bp_be_mmu_cmd_arbiter
// Purpose  : Shares the single MMU command port between the memory pipe and
//            the page-table walker. Registers the granted command, holds it
//            until the MMU accepts it, tracks the one outstanding response
//            and replays pipe commands that miss, up to a bounded count.
// Revision : 1.0  initial release
// ============================================================================
module bp_be_mmu_cmd_arbiter #(
  parameter int cmd_width_p    = 128,
  parameter int replay_limit_p = 3,
  parameter int replay_delay_p = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,

  input  logic [cmd_width_p-1:0] pipe_cmd_i,
  input  logic                   pipe_cmd_v_i,
  output logic                   pipe_cmd_ready_o,

  input  logic [cmd_width_p-1:0] ptw_cmd_i,
  input  logic                   ptw_cmd_v_i,
  output logic                   ptw_cmd_ready_o,

  input  logic                   flush_i,

  output logic [cmd_width_p-1:0] mmu_cmd_o,
  output logic                   mmu_cmd_v_o,
  input  logic                   mmu_cmd_ready_i,

  input  logic                   resp_v_i,
  input  logic                   miss_v_i,

  output logic                   busy_o,
  output logic                   fail_o
);

  // Counter widths; each counter is kept at least one bit wide so that
  // degenerate parameter choices still elaborate.
  localparam int C_CNT_W = (replay_limit_p < 1) ? 1 : $clog2(replay_limit_p + 1);
  localparam int C_DLY_W = (replay_delay_p < 2) ? 1 : $clog2(replay_delay_p);
  localparam logic [C_CNT_W-1:0] C_LIMIT    = C_CNT_W'(replay_limit_p);
  localparam logic [C_DLY_W-1:0] C_DLY_LAST = C_DLY_W'(replay_delay_p - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_REPLAY = 2'd3
  } state_t;

  state_t                   r_state;
  logic [cmd_width_p-1:0]   r_cmd;
  logic                     r_cmd_v;
  logic                     r_fail;
  logic                     r_rr;          // 1: pipe wins the next tie
  logic                     r_owner_pipe;  // current command came from the pipe
  logic [C_CNT_W-1:0]       r_cnt;         // replays already issued for this command
  logic [C_DLY_W-1:0]       r_dly;         // cycles spent in REPLAY so far

  logic w_idle;
  logic w_pipe_req;
  logic w_pipe_gnt;
  logic w_ptw_gnt;
  logic w_kill;

  // A flush in IDLE masks the pipe request, so the PTW may still be granted.
  assign w_idle     = (r_state == S_IDLE);
  assign w_pipe_req = pipe_cmd_v_i & ~flush_i;
  assign w_ptw_gnt  = w_idle & ptw_cmd_v_i & (~w_pipe_req | ~r_rr);
  assign w_pipe_gnt = w_idle & w_pipe_req  & (~ptw_cmd_v_i | r_rr);
  // Flush only ever cancels work owned by the pipe.
  assign w_kill     = flush_i & r_owner_pipe;

  assign pipe_cmd_ready_o = w_pipe_gnt;
  assign ptw_cmd_ready_o  = w_ptw_gnt;
  assign mmu_cmd_o        = r_cmd;
  assign mmu_cmd_v_o      = r_cmd_v;
  assign fail_o           = r_fail;
  assign busy_o           = (r_state != S_IDLE);

  // Arbitration / issue / response / replay state machine with registered outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state      <= S_IDLE;
      r_cmd        <= '0;
      r_cmd_v      <= 1'b0;
      r_fail       <= 1'b0;
      r_rr         <= 1'b0;
      r_owner_pipe <= 1'b0;
      r_cnt        <= '0;
      r_dly        <= '0;
    end else begin
      r_fail <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pipe_gnt || w_ptw_gnt) begin
            r_cmd        <= w_pipe_gnt ? pipe_cmd_i : ptw_cmd_i;
            r_owner_pipe <= w_pipe_gnt;
            r_rr         <= w_ptw_gnt;
            r_cnt        <= '0;
            r_dly        <= '0;
            r_cmd_v      <= 1'b1;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // A flush coinciding with ready still lets the MMU take the
          // command; its response later arrives in IDLE and is ignored.
          if (w_kill) begin
            r_cmd_v <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else if (mmu_cmd_ready_i) begin
            r_cmd_v <= 1'b0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_kill) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else if (resp_v_i) begin
            if (!miss_v_i || !r_owner_pipe) begin
              r_cnt   <= '0;
              r_state <= S_IDLE;
            end else if (r_cnt < C_LIMIT) begin
              r_cnt   <= r_cnt + C_CNT_W'(1);
              r_dly   <= '0;
              r_state <= S_REPLAY;
            end else begin
              r_fail  <= 1'b1;
              r_cnt   <= '0;
              r_state <= S_IDLE;
            end
          end
        end
        S_REPLAY: begin
          // REPLAY lasts exactly replay_delay_p cycles before re-issue.
          if (w_kill) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else if (r_dly == C_DLY_LAST) begin
            r_dly   <= '0;
            r_cmd_v <= 1'b1;
            r_state <= S_ISSUE;
          end else begin
            r_dly <= r_dly + C_DLY_W'(1);
          end
        end
        default: begin
          r_cmd_v <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bp_be_mmu_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_be_mmu_cmd_arbiter
// Purpose  : Directed self-checking bench for bp_be_mmu_cmd_arbiter.
//            Inputs change and outputs are sampled 1 time unit after the
//            rising edge; each "cycle" below starts at that point.
// Revision : 1.0  initial release
// ============================================================================
module tb_bp_be_mmu_cmd_arbiter;

  localparam int W     = 128;
  localparam int LIMIT = 3;
  localparam int DELAY = 4;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic [W-1:0] pipe_cmd_i, ptw_cmd_i, mmu_cmd_o;
  logic         pipe_cmd_v_i, pipe_cmd_ready_o;
  logic         ptw_cmd_v_i, ptw_cmd_ready_o;
  logic         flush_i, mmu_cmd_v_o, mmu_cmd_ready_i;
  logic         resp_v_i, miss_v_i, busy_o, fail_o;

  int tests = 0;
  int fails = 0;

  bp_be_mmu_cmd_arbiter #(
    .cmd_width_p   (W),
    .replay_limit_p(LIMIT),
    .replay_delay_p(DELAY)
  ) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .pipe_cmd_i      (pipe_cmd_i),
    .pipe_cmd_v_i    (pipe_cmd_v_i),
    .pipe_cmd_ready_o(pipe_cmd_ready_o),
    .ptw_cmd_i       (ptw_cmd_i),
    .ptw_cmd_v_i     (ptw_cmd_v_i),
    .ptw_cmd_ready_o (ptw_cmd_ready_o),
    .flush_i         (flush_i),
    .mmu_cmd_o       (mmu_cmd_o),
    .mmu_cmd_v_o     (mmu_cmd_v_o),
    .mmu_cmd_ready_i (mmu_cmd_ready_i),
    .resp_v_i        (resp_v_i),
    .miss_v_i        (miss_v_i),
    .busy_o          (busy_o),
    .fail_o          (fail_o)
  );

  always #5 clk_i = ~clk_i;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Idle-cycle checks of all registered outputs.
  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, W'(busy_o), W'(0));
    chk({tag, "_v"},    W'(mmu_cmd_v_o), W'(0));
    chk({tag, "_fail"}, W'(fail_o), W'(0));
  endtask

  logic [W-1:0] exp_cmd;
  bit           exp_ptw;

  initial begin
    reset_i = 1'b1;
    pipe_cmd_i = '0; pipe_cmd_v_i = 1'b0;
    ptw_cmd_i  = '0; ptw_cmd_v_i  = 1'b0;
    flush_i = 1'b0; mmu_cmd_ready_i = 1'b1;
    resp_v_i = 1'b0; miss_v_i = 1'b0;

    // ---------------- reset state ----------------
    #12;
    chk_idle("rst");
    chk("rst_cmd", mmu_cmd_o, W'(0));
    chk("rst_pipe_rdy", W'(pipe_cmd_ready_o), W'(0));
    chk("rst_ptw_rdy",  W'(ptw_cmd_ready_o),  W'(0));
    tick();
    reset_i = 1'b0;

    // ---------------- A: pipe only, hit ----------------
    pipe_cmd_i = W'(128'h1111); pipe_cmd_v_i = 1'b1;
    #1;
    chk("A_pipe_rdy", W'(pipe_cmd_ready_o), W'(1));
    chk("A_ptw_rdy",  W'(ptw_cmd_ready_o),  W'(0));
    tick();                      // N+1
    pipe_cmd_v_i = 1'b0;
    chk("A_v", W'(mmu_cmd_v_o), W'(1));
    chk("A_cmd", mmu_cmd_o, W'(128'h1111));
    chk("A_busy_issue", W'(busy_o), W'(1));
    tick();                      // WAIT
    chk("A_v_wait", W'(mmu_cmd_v_o), W'(0));
    chk("A_busy_wait", W'(busy_o), W'(1));
    resp_v_i = 1'b1; miss_v_i = 1'b0;
    tick();
    resp_v_i = 1'b0;
    chk_idle("A_done");

    // ---------------- B: round-robin, both valid ----------------
    // rr is 0 after a pipe grant, so order is PTW, pipe, PTW, pipe.
    pipe_cmd_v_i = 1'b1; ptw_cmd_v_i = 1'b1;
    for (int g = 0; g < 4; g++) begin
      pipe_cmd_i = W'(32'h2000 + g);
      ptw_cmd_i  = W'(32'h3000 + g);
      exp_ptw    = (g % 2 == 0);
      exp_cmd    = exp_ptw ? W'(32'h3000 + g) : W'(32'h2000 + g);
      #1;
      chk($sformatf("B%0d_ptw_rdy", g),  W'(ptw_cmd_ready_o),  W'(exp_ptw));
      chk($sformatf("B%0d_pipe_rdy", g), W'(pipe_cmd_ready_o), W'(!exp_ptw));
      tick();                    // ISSUE
      chk($sformatf("B%0d_cmd", g), mmu_cmd_o, exp_cmd);
      chk($sformatf("B%0d_v", g), W'(mmu_cmd_v_o), W'(1));
      chk($sformatf("B%0d_rdy_busy", g), W'({pipe_cmd_ready_o, ptw_cmd_ready_o}), W'(0));
      tick();                    // WAIT
      resp_v_i = 1'b1;
      tick();                    // back in IDLE
      resp_v_i = 1'b0;
    end
    pipe_cmd_v_i = 1'b0; ptw_cmd_v_i = 1'b0;
    chk_idle("B_done");

    // ---------------- C: miss 3x then hit ----------------
    // Each miss is followed by DELAY idle cycles in REPLAY, then re-issue.
    pipe_cmd_i = W'(128'hABCD); pipe_cmd_v_i = 1'b1;
    #1;
    chk("C_pipe_rdy", W'(pipe_cmd_ready_o), W'(1));
    tick();
    pipe_cmd_v_i = 1'b0;
    pipe_cmd_i = W'(128'hDEAD);  // must not leak into the replayed command
    for (int a = 0; a < 4; a++) begin
      chk($sformatf("C%0d_v", a), W'(mmu_cmd_v_o), W'(1));
      chk($sformatf("C%0d_cmd", a), mmu_cmd_o, W'(128'hABCD));
      tick();                    // WAIT
      resp_v_i = 1'b1; miss_v_i = (a < 3);
      tick();
      resp_v_i = 1'b0; miss_v_i = 1'b0;
      chk($sformatf("C%0d_fail", a), W'(fail_o), W'(0));
      if (a < 3) begin
        for (int d = 0; d < DELAY; d++) begin
          chk($sformatf("C%0d_gap%0d", a, d), W'({busy_o, mmu_cmd_v_o}), W'(2'b10));
          tick();
        end
      end
    end
    chk_idle("C_done");

    // ---------------- D: miss 4x, abandoned ----------------
    pipe_cmd_i = W'(128'h4444); pipe_cmd_v_i = 1'b1;
    tick();
    pipe_cmd_v_i = 1'b0;
    for (int a = 0; a < 4; a++) begin
      chk($sformatf("D%0d_v", a), W'(mmu_cmd_v_o), W'(1));
      tick();
      resp_v_i = 1'b1; miss_v_i = 1'b1;
      tick();
      resp_v_i = 1'b0; miss_v_i = 1'b0;
      if (a < 3) begin
        chk($sformatf("D%0d_fail", a), W'(fail_o), W'(0));
        repeat (DELAY) tick();
      end
    end
    chk("D_fail_pulse", W'(fail_o), W'(1));
    chk("D_busy", W'(busy_o), W'(0));
    tick();
    chk_idle("D_after");

    // ---------------- E: ready held low, flush in cycle 3 ----------------
    mmu_cmd_ready_i = 1'b0;
    pipe_cmd_i = W'(128'h5555); pipe_cmd_v_i = 1'b1;
    tick();                      // cycle 1
    pipe_cmd_v_i = 1'b0;
    pipe_cmd_i = W'(128'h9999);
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("E%0d_v", c), W'(mmu_cmd_v_o), W'(1));
      chk($sformatf("E%0d_cmd", c), mmu_cmd_o, W'(128'h5555));
      if (c == 3) flush_i = 1'b1;
      tick();
    end
    flush_i = 1'b0;
    chk_idle("E4");              // cycle 4: valid dropped
    // Flush in IDLE masks the pipe request.
    pipe_cmd_v_i = 1'b1; flush_i = 1'b1;
    #1;
    chk("E_flush_block", W'(pipe_cmd_ready_o), W'(0));
    pipe_cmd_v_i = 1'b0; flush_i = 1'b0;
    tick();
    tick();

    // ---------------- PTW owner ignores flush ----------------
    ptw_cmd_i = W'(128'h7777); ptw_cmd_v_i = 1'b1;
    tick();                      // ISSUE, ready still low
    ptw_cmd_v_i = 1'b0;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("P_v_kept", W'(mmu_cmd_v_o), W'(1));
    chk("P_cmd_kept", mmu_cmd_o, W'(128'h7777));
    mmu_cmd_ready_i = 1'b1;
    tick();                      // WAIT, rr now 1

    // ---------------- F: async reset in WAIT ----------------
    #3;
    reset_i = 1'b1;
    #1;
    chk("F_cmd", mmu_cmd_o, W'(0));
    chk("F_busy", W'(busy_o), W'(0));
    #1;
    reset_i = 1'b0;
    pipe_cmd_v_i = 1'b1; ptw_cmd_v_i = 1'b1;
    #1;
    chk("F_ptw_rdy",  W'(ptw_cmd_ready_o),  W'(1));
    chk("F_pipe_rdy", W'(pipe_cmd_ready_o), W'(0));
    pipe_cmd_v_i = 1'b0; ptw_cmd_v_i = 1'b0;
    tick();

    // ---------------- G: flush same cycle as a miss ----------------
    pipe_cmd_i = W'(128'h6666); pipe_cmd_v_i = 1'b1;
    tick();                      // ISSUE
    pipe_cmd_v_i = 1'b0;
    tick();                      // WAIT
    resp_v_i = 1'b1; miss_v_i = 1'b1; flush_i = 1'b1;
    tick();
    resp_v_i = 1'b0; miss_v_i = 1'b0; flush_i = 1'b0;
    chk_idle("G1");
    repeat (DELAY + 1) tick();
    chk_idle("G_no_replay");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
